// File: rtl/ctech_lib_nor_reduce_dbnc.sv
// NOR/OR reduction of a vector. The reduced value is delayed by a register
// pipeline and then debounced, with one-cycle rise/fall pulses.
module ctech_lib_nor_reduce_dbnc #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1,
  parameter int DBNC  = 4,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic             o1_raw,
  output logic             o1,
  output logic             rise,
  output logic             fall,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(DBNC + 1);
  localparam logic [CW:0]   DBNC_W = (CW+1)'(DBNC);
  localparam logic [CW-1:0] DBNC_C = CW'(DBNC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  logic w_raw;
  assign w_raw = (MODE == 1) ? (|a) : ~(|a);

  generate
    if (PIPE == 0) begin : g_nopipe
      assign o1_raw = w_raw;
    end else begin : g_pipe
      logic [PIPE-1:0] r_pipe;
      logic [PIPE:0]   w_shift;
      assign w_shift = {r_pipe, w_raw};
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_pipe <= '0;
        else       r_pipe <= w_shift[PIPE-1:0];
      end
      assign o1_raw = r_pipe[PIPE-1];
    end
  endgenerate

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_inc;
  logic          w_last;
  logic [CW-1:0] w_cnt_sat;

  // w_last marks the DBNC-th consecutive enabled sample of the new level.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc >= DBNC_W);
  assign w_cnt_sat = w_last ? DBNC_C : w_cnt_inc[CW-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      o1      <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (r_state)
          ST_LO: begin
            if (o1_raw) begin
              if (DBNC == 1) begin
                r_state <= ST_HI;
                r_cnt   <= '0;
                o1      <= 1'b1;
                rise    <= 1'b1;
              end else begin
                r_state <= ST_CHK_HI;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ST_CHK_HI: begin
            if (o1_raw) begin
              if (w_last) begin
                r_state <= ST_HI;
                r_cnt   <= '0;
                o1      <= 1'b1;
                rise    <= 1'b1;
              end else begin
                r_cnt <= w_cnt_sat;
              end
            end else begin
              r_state <= ST_LO;
              r_cnt   <= '0;
            end
          end
          ST_HI: begin
            if (!o1_raw) begin
              if (DBNC == 1) begin
                r_state <= ST_LO;
                r_cnt   <= '0;
                o1      <= 1'b0;
                fall    <= 1'b1;
              end else begin
                r_state <= ST_CHK_LO;
                r_cnt   <= CNT_ONE;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          ST_CHK_LO: begin
            if (!o1_raw) begin
              if (w_last) begin
                r_state <= ST_LO;
                r_cnt   <= '0;
                o1      <= 1'b0;
                fall    <= 1'b1;
              end else begin
                r_cnt <= w_cnt_sat;
              end
            end else begin
              r_state <= ST_HI;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= ST_LO;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/ctech_lib_nor_reduce_dbnc.md
CTECH_LIB_NOR_REDUCE_DBNC -- requirements
Module: ctech_lib_nor_reduce_dbnc

Interface
REQ-001 Parameter WIDTH, default 32, number of input bits reduced (legal 2..256).
REQ-002 Parameter PIPE, default 1, register stages between input and o1_raw (legal 0..3).
REQ-003 Parameter DBNC, default 4, consecutive enabled samples required to change o1 (legal 1..255).
REQ-004 Parameter MODE, default 0, reduction function: 0 = NOR of all bits, 1 = OR of all bits.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstb  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  debounce sample enable; 0 freezes debounce state and counter.
REQ-008 a  input  WIDTH  vector to reduce.
REQ-009 o1_raw  output  1  reduced value delayed by PIPE cycles, undebounced.
REQ-010 o1  output  1  debounced reduced value.
REQ-011 rise  output  1  one-cycle pulse coincident with o1 going 0->1.
REQ-012 fall  output  1  one-cycle pulse coincident with o1 going 1->0.

Function
REQ-013 raw = ~|a when MODE=0, |a when MODE=1; pure combinational.
REQ-014 o1_raw equals raw delayed exactly PIPE rising edges; PIPE=0 makes o1_raw combinational from a.
REQ-015 Pipeline registers advance every cycle regardless of en.
REQ-016 Debounce FSM states: LO, CHK_HI, HI, CHK_LO; o1=0 in LO/CHK_HI, o1=1 in HI/CHK_LO; o1 is registered.
REQ-017 Counter cnt, width clog2(DBNC+1), saturates at DBNC, never wraps.
REQ-018 LO: en & o1_raw=1 -> CHK_HI with cnt=1, or directly HI when DBNC=1; else hold, cnt=0.
REQ-019 CHK_HI: en & o1_raw=1 -> cnt+1, move to HI with cnt=0 on the edge where cnt+1=DBNC; en & o1_raw=0 -> LO, cnt=0.
REQ-020 HI/CHK_LO: mirror of LO/CHK_HI with o1_raw polarity inverted; o1 falls on the DBNC-th consecutive enabled sample of o1_raw=0.
REQ-021 en=0 on an edge: state and cnt unchanged; that edge is not counted and does not break a run.
REQ-022 rise/fall registered, high for exactly the cycle following the edge that changed o1; never both high; back-to-back transitions impossible when DBNC>=2.
REQ-023 Latency a->o1 for steady input with en=1: PIPE+DBNC edges.

Reset
REQ-024 rstb=0 immediately (no clock) forces all pipeline registers to 0, state LO, cnt=0, o1=0, rise=0, fall=0.
REQ-025 During reset o1_raw equals 0 for PIPE>=1; equals raw for PIPE=0.
REQ-026 Reset asserted mid-CHK_HI or CHK_LO discards the partial count; no rise/fall pulse is generated on reset entry or exit.
REQ-027 After rstb deasserts, first state update occurs on the first rising clk edge.

Verification
REQ-028 WIDTH=8,PIPE=1,DBNC=3,MODE=0, a=8'h00, en=1, release reset -> o1_raw=1 after edge 1, o1=1 and rise=1 after edge 4, rise=0 after edge 5.
REQ-029 Same config, o1=0, a=8'h00 for 2 cycles then 8'h01 -> o1 stays 0, rise never asserts, FSM returns to LO.
REQ-030 Same config, o1=1, a=8'h80 held -> o1=0 and fall=1 exactly 4 edges after a changes, fall single-cycle.
REQ-031 Same config, in CHK_HI with cnt=1, en=0 for 5 cycles then en=1 with a=8'h00 -> o1 rises after 2 further enabled edges.
REQ-032 In CHK_LO with cnt=2, pull rstb low between edges -> o1=0, rise=fall=0 before next clk edge; after release o1 rebuilds from LO.
REQ-033 WIDTH=4,PIPE=0,DBNC=1,MODE=1, a=4'h0->4'h2 -> o1_raw=1 same cycle, o1=1 and rise=1 after next edge.
